// File: rtl/stack_pointer_unit_pkg.sv
// Shared types and ATmega32A memory-map constants for the stack pointer unit.
package stack_pointer_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PUSH = 2'd1,
      POP  = 2'd2,
      DONE = 2'd3
   } sp_state_e;

   typedef logic [1:0] nbytes_t;

   localparam logic [15:0] SRAM_START  = 16'h0060;
   localparam logic [15:0] RAMEND      = 16'h085F;
   localparam logic [7:0]  SPH_IO_ADDR = 8'h3E;
   localparam logic [7:0]  SPL_IO_ADDR = 8'h3D;

endpackage

// File: rtl/sp_byte_register.sv
// One byte (or partial byte) of the stack pointer with load enable and reset value.
module sp_byte_register #(
   parameter int          W   = 8,
   parameter logic [W-1:0] RST = '0
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!clr_n)  q <= RST;
      else if (en) q <= d;
   end

endmodule

// File: rtl/stack_pointer_unit.sv
// AVR stack pointer with SPH/SPL byte writes and autonomous multi-byte PUSH/POP
// sequencing against data memory, plus sticky stack-limit flags.
module stack_pointer_unit
   import stack_pointer_unit_pkg::*;
#(
   parameter int          SP_WIDTH    = 16,
   parameter logic [15:0] RESET_VALUE = 16'h0000,
   parameter logic [15:0] STACK_LO    = SRAM_START,
   parameter logic [15:0] STACK_HI    = RAMEND,
   parameter int          MAX_BYTES   = 3
) (
   input  logic                   clk,
   input  logic                   clr_n,
   input  logic [7:0]             data_inH,
   input  logic [7:0]             data_inL,
   input  logic                   WE_H,
   input  logic                   WE_L,
   input  logic                   push,
   input  logic                   pop,
   input  logic [1:0]             nbytes,
   input  logic [8*MAX_BYTES-1:0] push_data,
   output logic [8*MAX_BYTES-1:0] pop_data,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            mem_addr,
   output logic [7:0]             mem_wdata,
   output logic                   mem_we,
   output logic                   mem_re,
   input  logic [7:0]             mem_rdata,
   input  logic                   mem_ready,
   output logic [7:0]             spH,
   output logic [7:0]             spL,
   output logic [15:0]            sp,
   output logic                   stk_ovf,
   output logic                   stk_unf
);

   localparam int HW = SP_WIDTH - 8;
   localparam int DW = 8 * MAX_BYTES;

   sp_state_e           state;
   nbytes_t             n, k, pidx;
   logic [DW-1:0]       push_buf, pop_buf, pop_next;
   logic [HW-1:0]       sp_hi, hi_d;
   logic [7:0]          sp_lo, lo_d;
   logic                hi_en, lo_en, step, last, out_of_range;
   logic [SP_WIDTH-1:0] sp_r, sp_dec, sp_inc;

   assign sp_r   = {sp_hi, sp_lo};
   assign sp_dec = sp_r - SP_WIDTH'(1);
   assign sp_inc = sp_r + SP_WIDTH'(1);

   assign step = ((state == PUSH) || (state == POP)) && mem_ready;
   assign last = (k == n - 2'd1);
   assign pidx = n - 2'd1 - k;

   // Push writes at SP then decrements; pop increments first and reads SP+1.
   assign mem_addr     = 16'((state == POP) ? sp_inc : sp_r);
   assign mem_wdata    = push_buf[k*8 +: 8];
   assign mem_we       = (state == PUSH);
   assign mem_re       = (state == POP);
   assign busy         = mem_we || mem_re;
   assign done         = (state == DONE);
   assign out_of_range = (mem_addr < STACK_LO) || (mem_addr > STACK_HI);

   assign sp  = 16'(sp_r);
   assign spH = sp[15:8];
   assign spL = sp[7:0];

   always_comb begin
      pop_next            = pop_buf;
      pop_next[pidx*8 +: 8] = mem_rdata;
   end

   // SP load mux: I/O writes in IDLE, +/-1 on each acknowledged memory beat.
   always_comb begin
      hi_en = 1'b0;
      lo_en = 1'b0;
      hi_d  = data_inH[HW-1:0];
      lo_d  = data_inL;
      if (state == IDLE) begin
         hi_en = WE_H;
         lo_en = WE_L;
      end else if (step) begin
         hi_en = 1'b1;
         lo_en = 1'b1;
         {hi_d, lo_d} = (state == PUSH) ? sp_dec : sp_inc;
      end
   end

   sp_byte_register #(.W(HW), .RST(RESET_VALUE[SP_WIDTH-1:8])) u_sph (
      .clk(clk), .clr_n(clr_n), .en(hi_en), .d(hi_d), .q(sp_hi)
   );

   sp_byte_register #(.W(8), .RST(RESET_VALUE[7:0])) u_spl (
      .clk(clk), .clr_n(clr_n), .en(lo_en), .d(lo_d), .q(sp_lo)
   );

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state    <= IDLE;
         n        <= 2'd1;
         k        <= '0;
         push_buf <= '0;
         pop_buf  <= '0;
         pop_data <= '0;
         stk_ovf  <= 1'b0;
         stk_unf  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               k <= '0;
               if (WE_H || WE_L) begin
                  stk_ovf <= 1'b0;
                  stk_unf <= 1'b0;
               end
               if (push) begin
                  state    <= PUSH;
                  n        <= (nbytes == 2'd0) ? 2'd1 : nbytes;
                  push_buf <= push_data;
               end else if (pop) begin
                  state   <= POP;
                  n       <= (nbytes == 2'd0) ? 2'd1 : nbytes;
                  pop_buf <= '0;
               end
            end
            PUSH: if (mem_ready) begin
               if (out_of_range) stk_ovf <= 1'b1;
               k <= k + 2'd1;
               if (last) state <= DONE;
            end
            POP: if (mem_ready) begin
               if (out_of_range) stk_unf <= 1'b1;
               pop_buf <= pop_next;
               k       <= k + 2'd1;
               if (last) begin
                  state    <= DONE;
                  pop_data <= pop_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed bench for stack_pointer_unit with a behavioural byte memory.
module tb_stack_pointer_unit;

   logic        clk = 1'b0;
   logic        clr_n;
   logic [7:0]  data_inH, data_inL;
   logic        WE_H, WE_L, push, pop;
   logic [1:0]  nbytes;
   logic [23:0] push_data, pop_data;
   logic        busy, done, mem_we, mem_re, mem_ready;
   logic [15:0] mem_addr, sp;
   logic [7:0]  mem_wdata, mem_rdata, spH, spL;
   logic        stk_ovf, stk_unf;
   logic [7:0]  mem [0:65535];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   stack_pointer_unit dut (
      .clk(clk), .clr_n(clr_n), .data_inH(data_inH), .data_inL(data_inL),
      .WE_H(WE_H), .WE_L(WE_L), .push(push), .pop(pop), .nbytes(nbytes),
      .push_data(push_data), .pop_data(pop_data), .busy(busy), .done(done),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .spH(spH), .spL(spL), .sp(sp),
      .stk_ovf(stk_ovf), .stk_unf(stk_unf)
   );

   // Address 0860 is never written by the bench; it reads back a fixed pattern.
   assign mem_rdata = (mem_addr == 16'h0860) ? 8'hAB : mem[mem_addr];
   always @(posedge clk) if (mem_we && mem_ready) mem[mem_addr] <= mem_wdata;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_sp(input logic [15:0] v);
      WE_H = 1'b1; WE_L = 1'b1; data_inH = v[15:8]; data_inL = v[7:0];
      tick();
      WE_H = 1'b0; WE_L = 1'b0;
   endtask

   task automatic test_reset();
      clr_n = 1'b0;
      tick();
      clr_n = 1'b1;
      total++; if (sp !== 16'h0000) begin bad++; $display("FAIL reset_sp got=%h exp=0000", sp); end
      total++; if ({busy, done, mem_we, mem_re, stk_ovf, stk_unf} !== 6'b0) begin
         bad++; $display("FAIL reset_ctl got=%b exp=000000", {busy, done, mem_we, mem_re, stk_ovf, stk_unf}); end
      total++; if (pop_data !== 24'h0) begin bad++; $display("FAIL reset_pop_data got=%h exp=000000", pop_data); end
   endtask

   task automatic test_io_write();
      write_sp(16'h085F);
      total++; if (sp !== 16'h085F) begin bad++; $display("FAIL io_sp got=%h exp=085F", sp); end
      total++; if ({spH, spL} !== 16'h085F) begin bad++; $display("FAIL io_bytes got=%h%h exp=085F", spH, spL); end
      total++; if ({stk_ovf, stk_unf} !== 2'b00) begin bad++; $display("FAIL io_flags got=%b exp=00", {stk_ovf, stk_unf}); end
   endtask

   task automatic test_push();
      mem_ready = 1'b1; push = 1'b1; nbytes = 2'd2; push_data = 24'h001234;
      tick();
      push = 1'b0;
      total++; if ({busy, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h085F, 8'h34}) begin
         bad++; $display("FAIL push_beat0 got=%b%b %h %h exp=11 085F 34", busy, mem_we, mem_addr, mem_wdata); end
      tick();
      total++; if ({mem_addr, mem_wdata, sp} !== {16'h085E, 8'h12, 16'h085E}) begin
         bad++; $display("FAIL push_beat1 got=%h %h sp=%h exp=085E 12 sp=085E", mem_addr, mem_wdata, sp); end
      tick();
      total++; if ({done, busy, mem_we, sp} !== {3'b100, 16'h085D}) begin
         bad++; $display("FAIL push_done got=%b%b%b sp=%h exp=100 sp=085D", done, busy, mem_we, sp); end
      total++; if ({mem[16'h085F], mem[16'h085E]} !== 16'h3412) begin
         bad++; $display("FAIL push_mem got=%h%h exp=3412", mem[16'h085F], mem[16'h085E]); end
      tick();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL push_done_pulse got=%b exp=0", done); end
   endtask

   task automatic test_pop();
      pop = 1'b1; nbytes = 2'd2;
      tick();
      pop = 1'b0;
      total++; if ({mem_re, mem_we, mem_addr} !== {2'b10, 16'h085E}) begin
         bad++; $display("FAIL pop_beat0 got=%b%b %h exp=10 085E", mem_re, mem_we, mem_addr); end
      tick();
      total++; if ({mem_addr, sp} !== {16'h085F, 16'h085E}) begin
         bad++; $display("FAIL pop_beat1 got=%h sp=%h exp=085F sp=085E", mem_addr, sp); end
      tick();
      total++; if ({done, sp, pop_data} !== {1'b1, 16'h085F, 24'h001234}) begin
         bad++; $display("FAIL pop_done got=%b sp=%h data=%h exp=1 085F 001234", done, sp, pop_data); end
      total++; if ({stk_ovf, stk_unf} !== 2'b00) begin bad++; $display("FAIL pop_flags got=%b exp=00", {stk_ovf, stk_unf}); end
      tick();
   endtask

   task automatic test_underflow();
      pop = 1'b1; nbytes = 2'd1;
      tick();
      pop = 1'b0;
      total++; if ({mem_re, mem_addr} !== {1'b1, 16'h0860}) begin
         bad++; $display("FAIL unf_addr got=%b %h exp=1 0860", mem_re, mem_addr); end
      tick();
      total++; if ({done, stk_unf, sp, pop_data} !== {2'b11, 16'h0860, 24'h0000AB}) begin
         bad++; $display("FAIL unf_done got=%b%b sp=%h data=%h exp=11 0860 0000AB", done, stk_unf, sp, pop_data); end
      tick();
      WE_L = 1'b1; data_inL = 8'h5F;
      tick();
      WE_L = 1'b0;
      total++; if ({stk_unf, sp} !== {1'b0, 16'h085F}) begin
         bad++; $display("FAIL unf_clear got=%b sp=%h exp=0 085F", stk_unf, sp); end
   endtask

   task automatic test_wait_states();
      mem_ready = 1'b0; push = 1'b1; nbytes = 2'd1; push_data = 24'h000077;
      tick();
      push = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++; if ({mem_we, mem_addr, mem_wdata, sp} !== {1'b1, 16'h085F, 8'h77, 16'h085F}) begin
            bad++; $display("FAIL wait_hold%0d got=%b %h %h sp=%h exp=1 085F 77 085F", i, mem_we, mem_addr, mem_wdata, sp); end
         tick();
      end
      mem_ready = 1'b1;
      tick();
      total++; if ({done, sp, mem[16'h085F]} !== {1'b1, 16'h085E, 8'h77}) begin
         bad++; $display("FAIL wait_done got=%b sp=%h mem=%h exp=1 085E 77", done, sp, mem[16'h085F]); end
      tick();
   endtask

   task automatic test_overflow();
      write_sp(16'h005F);
      push = 1'b1; pop = 1'b1; nbytes = 2'd0; push_data = 24'h0000C3;
      tick();
      push = 1'b0; pop = 1'b0;
      total++; if ({mem_we, mem_re, mem_addr} !== {2'b10, 16'h005F}) begin
         bad++; $display("FAIL ovf_prio got=%b%b %h exp=10 005F", mem_we, mem_re, mem_addr); end
      tick();
      total++; if ({done, stk_ovf, sp} !== {2'b11, 16'h005E}) begin
         bad++; $display("FAIL ovf_done got=%b%b sp=%h exp=11 005E", done, stk_ovf, sp); end
      tick();
      WE_H = 1'b1; data_inH = 8'h08;
      tick();
      WE_H = 1'b0;
      total++; if ({stk_ovf, sp} !== {1'b0, 16'h085E}) begin
         bad++; $display("FAIL ovf_clear got=%b sp=%h exp=0 085E", stk_ovf, sp); end
   endtask

   task automatic test_reset_mid_pop();
      write_sp(16'h085D);
      pop = 1'b1; nbytes = 2'd2;
      tick();
      pop = 1'b0;
      tick();
      total++; if ({mem_re, sp} !== {1'b1, 16'h085E}) begin
         bad++; $display("FAIL rstpop_mid got=%b sp=%h exp=1 085E", mem_re, sp); end
      clr_n = 1'b0;
      tick();
      clr_n = 1'b1;
      total++; if ({sp, busy, done, mem_we, mem_re, pop_data} !== {16'h0000, 4'b0000, 24'h0}) begin
         bad++; $display("FAIL rstpop_abort sp=%h ctl=%b%b%b%b data=%h exp=0000 0000 000000", sp, busy, done, mem_we, mem_re, pop_data); end
      tick();
      total++; if ({done, busy, sp} !== {2'b00, 16'h0000}) begin
         bad++; $display("FAIL rstpop_after got=%b%b sp=%h exp=00 0000", done, busy, sp); end
   endtask

   initial begin
      clr_n = 1'b0; WE_H = 1'b0; WE_L = 1'b0; data_inH = '0; data_inL = '0;
      push = 1'b0; pop = 1'b0; nbytes = '0; push_data = '0; mem_ready = 1'b1;
      tick();
      test_reset();
      test_io_write();
      test_push();
      test_pop();
      test_underflow();
      test_wait_states();
      test_overflow();
      test_reset_mid_pop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
